nios2_ocimem_arbiter: RTL

Sequences and arbitrates the Nios II on-chip debug monitor RAM (OCI memory) between two requesters. One is the JTAG debug slave's sysclk-side command strobes (take_action_ocimem_a/b, take_no_action_ocimem_a with jdo). The other is the CPU's Avalon debug_mem_slave. The block owns the JTAG address pointer, latches JTAG read data into MonDReg, and generates Avalon waitrequest. It sits between the debug slave wrapper and a single-port, 1-cycle-read-latency RAM.

---
 rtl/nios2_ocimem_arbiter_pkg.sv | 22 ++
 rtl/nios2_ocimem_jtag_cmd_latch.sv | 75 +++++++
 rtl/nios2_ocimem_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/nios2_ocimem_arbiter_pkg.sv
// Shared types and jdo field offsets for the Nios II OCI memory arbiter.
package nios2_ocimem_arbiter_pkg;

    localparam int JDO_W      = 38;
    localparam int ADDR_LSB   = 17;
    localparam int WDATA_LSB  = 3;
    localparam int RDLOAD_BIT = 35;

    typedef enum logic [1:0] {
        IDLE,
        JRD,
        CRD
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        LOAD,
        READ,
        WRITE
    } pend_kind_t;

endpackage

// File: rtl/nios2_ocimem_jtag_cmd_latch.sv
// Captures single-cycle JTAG ocimem strobes into a 1-deep pending command,
// resolving coincident strobes by priority and flagging any dropped strobe.
module nios2_ocimem_jtag_cmd_latch
    import nios2_ocimem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              pend_clear,
    input  logic              pend_to_read,
    output pend_kind_t        pend_kind,
    output logic [ADDR_W-1:0] pend_addr,
    output logic [DATA_W-1:0] pend_wdata,
    output logic              pend_rdload,
    output logic              jtag_overrun
);

    pend_kind_t strobe_kind;
    logic       strobe_any;
    logic       strobe_multi;
    logic       pend_valid;
    logic       unused_jdo;

    // NOTE: every variable written in always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        strobe_kind = NONE;
        if (take_action_ocimem_a)
            strobe_kind = LOAD;
        else if (take_no_action_ocimem_a)
            strobe_kind = READ;
        else if (take_action_ocimem_b)
            strobe_kind = WRITE;
    end

    assign strobe_any   = (strobe_kind != NONE);
    assign strobe_multi = (take_action_ocimem_a & take_no_action_ocimem_a)
                        | (take_action_ocimem_a & take_action_ocimem_b)
                        | (take_no_action_ocimem_a & take_action_ocimem_b);
    assign pend_valid   = (pend_kind != NONE);
    assign unused_jdo   = ^{jdo[JDO_W-1:RDLOAD_BIT+1], jdo[WDATA_LSB-1:0]};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_kind    <= NONE;
            pend_addr    <= '0;
            pend_wdata   <= '0;
            pend_rdload  <= 1'b0;
            jtag_overrun <= 1'b0;
        end else begin
            if (pend_clear)
                pend_kind <= NONE;
            else if (pend_to_read)
                pend_kind <= READ;

            // Capture only into an empty slot; the consumer never clears and refills in one cycle.
            if (strobe_any && !pend_valid) begin
                pend_kind   <= strobe_kind;
                pend_addr   <= jdo[ADDR_LSB +: ADDR_W];
                pend_wdata  <= jdo[WDATA_LSB +: DATA_W];
                pend_rdload <= jdo[RDLOAD_BIT];
            end

            if (strobe_multi || (strobe_any && pend_valid))
                jtag_overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Arbitrates the single-port OCI debug RAM between JTAG commands (auto-incrementing
// pointer, MonDReg capture) and the CPU Avalon debug_mem_slave, alternating on contention.
module nios2_ocimem_arbiter
    import nios2_ocimem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [JDO_W-1:0]  jdo,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [3:0]        avs_byteenable,
    input  logic              avs_debugaccess,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_overrun
);

    state_t            state_q, state_d;
    pend_kind_t        pend_kind;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;
    logic              pend_rdload;
    logic [ADDR_W-1:0] pointer;
    logic              last_grant_jtag;
    logic [DATA_W-1:0] readdata_q;
    logic              jtag_req, cpu_req, jtag_win;
    logic              pend_clear, pend_to_read, ptr_load, ptr_inc;
    logic              mon_load, rd_capture, grant_jtag, grant_cpu;

    nios2_ocimem_jtag_cmd_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmd_latch (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jdo                     (jdo),
        .pend_clear              (pend_clear),
        .pend_to_read            (pend_to_read),
        .pend_kind               (pend_kind),
        .pend_addr               (pend_addr),
        .pend_wdata              (pend_wdata),
        .pend_rdload             (pend_rdload),
        .jtag_overrun            (jtag_overrun)
    );

    assign jtag_req = (pend_kind == READ) || (pend_kind == WRITE);
    assign cpu_req  = avs_read | avs_write;
    // JTAG yields only when it had the previous grant and the CPU is waiting.
    assign jtag_win = jtag_req && !(last_grant_jtag && cpu_req);

    assign avs_readdata = (state_q == CRD) ? ram_rdata : readdata_q;

    always_comb begin
        state_d         = state_q;
        ram_addr        = pointer;
        ram_wren        = 1'b0;
        ram_byteen      = '0;
        ram_wdata       = '0;
        avs_waitrequest = 1'b1;
        ptr_load        = 1'b0;
        ptr_inc         = 1'b0;
        pend_clear      = 1'b0;
        pend_to_read    = 1'b0;
        mon_load        = 1'b0;
        rd_capture      = 1'b0;
        grant_jtag      = 1'b0;
        grant_cpu       = 1'b0;
        // Gating on reset_n drops the write strobe the instant reset asserts.
        if (reset_n) begin
            unique case (state_q)
                IDLE: begin
                    // LOAD needs no RAM port, so it retires alongside any CPU access.
                    if (pend_kind == LOAD) begin
                        ptr_load     = 1'b1;
                        pend_to_read = pend_rdload;
                        pend_clear   = !pend_rdload;
                    end
                    if (jtag_win) begin
                        if (pend_kind == WRITE) begin
                            ram_wren   = 1'b1;
                            ram_byteen = 4'hF;
                            ram_wdata  = pend_wdata;
                            ptr_inc    = 1'b1;
                            pend_clear = 1'b1;
                            grant_jtag = 1'b1;
                        end else begin
                            state_d = JRD;
                        end
                    end else if (cpu_req) begin
                        ram_addr = avs_address;
                        if (avs_write) begin
                            ram_wren        = avs_debugaccess;
                            ram_byteen      = avs_byteenable;
                            ram_wdata       = avs_writedata;
                            avs_waitrequest = 1'b0;
                            grant_cpu       = 1'b1;
                        end else begin
                            state_d = CRD;
                        end
                    end
                end
                JRD: begin
                    mon_load   = 1'b1;
                    ptr_inc    = 1'b1;
                    pend_clear = 1'b1;
                    grant_jtag = 1'b1;
                    state_d    = IDLE;
                end
                CRD: begin
                    ram_addr        = avs_address;
                    avs_waitrequest = 1'b0;
                    rd_capture      = 1'b1;
                    grant_cpu       = 1'b1;
                    state_d         = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            pointer         <= '0;
            last_grant_jtag <= 1'b0;
            MonDReg         <= '0;
            readdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (ptr_load)
                pointer <= pend_addr;
            else if (ptr_inc)
                pointer <= pointer + ADDR_W'(1);
            if (grant_jtag)
                last_grant_jtag <= 1'b1;
            else if (grant_cpu)
                last_grant_jtag <= 1'b0;
            if (mon_load)
                MonDReg <= ram_rdata;
            if (rd_capture)
                readdata_q <= ram_rdata;
        end
    end

endmodule
